// File: rtl/uart_alu_engine.sv
// ---------------------------------------------------------------------------
// uart_alu_engine
//   Byte-stream command processor placed between a UART receiver and a UART
//   transmitter. It parses command packets, runs echo / add / multiply over
//   32-bit little-endian operands, and serialises the response bytes.
//
//   Packet: opcode, reserved, LEN lo, LEN hi, then LEN-4 payload bytes.
//     0xEC ECHO : payload forwarded unchanged
//     0xA0 ADD  : sum of operands, mod 2^32, sent as 4 bytes LSB first
//     0xA1 MUL  : product of operands (low 32 bits), sent as 4 bytes LSB first
//   Rejected packets pulse cmd_error and have their payload discarded.
//
// Ports
//   clk            : single clock
//   rst            : asynchronous, active-low reset
//   s_axis_tdata   : command byte in
//   s_axis_tvalid  : command byte valid
//   s_axis_tready  : engine ready to accept a command byte
//   m_axis_tdata   : response byte out
//   m_axis_tvalid  : response byte valid
//   m_axis_tready  : transmitter ready to accept a response byte
//   busy           : high unless idle waiting for an opcode byte
//   cmd_error      : one-cycle pulse when a packet is rejected
// ---------------------------------------------------------------------------
module uart_alu_engine #(
  parameter int DATA_WIDTH    = 8,
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  cmd_error
);

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;

  typedef enum logic [2:0] {
    S_HDR,
    S_ECHO,
    S_OPERAND,
    S_ADD,
    S_MUL,
    S_SEND,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [1:0]               r_hdr_cnt;
  logic [DATA_WIDTH-1:0]    r_opcode;
  logic [DATA_WIDTH-1:0]    r_len_lo;
  logic [15:0]              r_cnt;       // payload bytes still to accept
  logic [1:0]               r_byte_cnt;  // byte position inside current operand
  logic                     r_first;     // next completed operand is the first
  logic [OPERAND_WIDTH-1:0] r_operand;   // assembled operand; multiplier during MUL
  logic [OPERAND_WIDTH-1:0] r_acc;       // accumulator; partial product during MUL
  logic [OPERAND_WIDTH-1:0] r_mcand;     // multiplicand, shifted left each MUL cycle
  logic [4:0]               r_mul_cnt;
  logic [1:0]               r_send_idx;
  logic                     r_m_tvalid;
  logic [DATA_WIDTH-1:0]    r_m_tdata;
  logic                     r_cmd_error;

  // Header decode, evaluated while the 4th header byte is on the bus.
  logic [15:0]              w_len;
  logic [15:0]              w_pay;
  logic                     w_len_ok;
  logic                     w_is_alu;
  logic                     w_hdr_err;
  logic [OPERAND_WIDTH-1:0] w_operand;
  logic [OPERAND_WIDTH-1:0] w_sum;
  logic [OPERAND_WIDTH-1:0] w_prod_next;
  logic [1:0]               w_send_idx_next;

  assign w_len     = {s_axis_tdata, r_len_lo};
  assign w_len_ok  = (w_len >= 16'd4);
  assign w_pay     = w_len - 16'd4;
  assign w_is_alu  = (r_opcode == OP_ADD) || (r_opcode == OP_MUL);
  assign w_hdr_err = !w_len_ok ||
                     !((r_opcode == OP_ECHO) ||
                       (w_is_alu && (w_len >= 16'd12) && (w_len[1:0] == 2'b00)));

  assign w_operand       = {s_axis_tdata, r_operand[OPERAND_WIDTH-1:DATA_WIDTH]};
  assign w_sum           = r_acc + r_operand;
  assign w_prod_next     = r_acc + (r_operand[0] ? r_mcand : '0);
  assign w_send_idx_next = r_send_idx + 2'd1;

  assign busy      = !((r_state == S_HDR) && (r_hdr_cnt == 2'd0));
  assign cmd_error = r_cmd_error;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and stream handshake outputs
  always_comb begin
    w_state_next  = r_state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = r_m_tvalid;
    m_axis_tdata  = r_m_tdata;
    case (r_state)
      S_HDR: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && (r_hdr_cnt == 2'd3)) begin
          if (w_hdr_err) begin
            // LEN<4 drains nothing; otherwise discard the declared payload
            w_state_next = (w_len_ok && (w_pay != 16'd0)) ? S_DRAIN : S_HDR;
          end else if (r_opcode == OP_ECHO) begin
            w_state_next = (w_pay != 16'd0) ? S_ECHO : S_HDR;
          end else begin
            w_state_next = S_OPERAND;
          end
        end
      end
      S_ECHO: begin
        // Pure pass-through: the transmitter's ready throttles the receiver
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        if (s_axis_tvalid && m_axis_tready && (r_cnt == 16'd1)) begin
          w_state_next = S_HDR;
        end
      end
      S_OPERAND: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && (r_byte_cnt == 2'd3) && !r_first) begin
          w_state_next = (r_opcode == OP_ADD) ? S_ADD : S_MUL;
        end
      end
      S_ADD: begin
        w_state_next = (r_cnt == 16'd0) ? S_SEND : S_OPERAND;
      end
      S_MUL: begin
        if (r_mul_cnt == 5'd31) begin
          w_state_next = (r_cnt == 16'd0) ? S_SEND : S_OPERAND;
        end
      end
      S_SEND: begin
        if (m_axis_tready && (r_send_idx == 2'd3)) begin
          w_state_next = S_HDR;
        end
      end
      S_DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && (r_cnt == 16'd1)) begin
          w_state_next = S_HDR;
        end
      end
      default: begin
        w_state_next = S_HDR;
      end
    endcase
  end

  // Datapath: header capture, operand assembly, arithmetic, response bytes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hdr_cnt   <= '0;
      r_opcode    <= '0;
      r_len_lo    <= '0;
      r_cnt       <= '0;
      r_byte_cnt  <= '0;
      r_first     <= 1'b0;
      r_operand   <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mul_cnt   <= '0;
      r_send_idx  <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tdata   <= '0;
      r_cmd_error <= 1'b0;
    end else begin
      r_cmd_error <= 1'b0;
      case (r_state)
        S_HDR: begin
          if (s_axis_tvalid) begin
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            case (r_hdr_cnt)
              2'd0: r_opcode <= s_axis_tdata;
              2'd2: r_len_lo <= s_axis_tdata;
              2'd3: begin
                r_cnt       <= w_len_ok ? w_pay : 16'd0;
                r_cmd_error <= w_hdr_err;
                r_first     <= 1'b1;
                r_byte_cnt  <= 2'd0;
              end
              default: ;
            endcase
          end
        end
        S_ECHO: begin
          if (s_axis_tvalid && m_axis_tready) begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DRAIN: begin
          if (s_axis_tvalid) begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_OPERAND: begin
          if (s_axis_tvalid) begin
            r_cnt      <= r_cnt - 16'd1;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_operand  <= w_operand;
            if (r_byte_cnt == 2'd3) begin
              if (r_first) begin
                r_acc   <= w_operand;
                r_first <= 1'b0;
              end else if (r_opcode == OP_MUL) begin
                // Product is rebuilt in r_acc from zero; old value becomes multiplicand
                r_mcand   <= r_acc;
                r_acc     <= '0;
                r_mul_cnt <= 5'd0;
              end
            end
          end
        end
        S_ADD: begin
          r_acc <= w_sum;
          if (r_cnt == 16'd0) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_sum[DATA_WIDTH-1:0];
            r_send_idx <= 2'd0;
          end
        end
        S_MUL: begin
          r_acc     <= w_prod_next;
          r_mcand   <= r_mcand << 1;
          r_operand <= r_operand >> 1;
          r_mul_cnt <= r_mul_cnt + 5'd1;
          if ((r_mul_cnt == 5'd31) && (r_cnt == 16'd0)) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_prod_next[DATA_WIDTH-1:0];
            r_send_idx <= 2'd0;
          end
        end
        S_SEND: begin
          if (m_axis_tready) begin
            if (r_send_idx == 2'd3) begin
              r_m_tvalid <= 1'b0;
              r_m_tdata  <= '0;
            end else begin
              r_send_idx <= w_send_idx_next;
              r_m_tdata  <= r_acc[{w_send_idx_next, 3'b000} +: DATA_WIDTH];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_engine.sv
`timescale 1ns/1ps
module tb_uart_alu_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       busy;
  logic       cmd_error;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int rdy_mode = 0;      // 0: always ready, 1: random, 2: follows man_rdy
  logic man_rdy = 1'b0;
  bit gap_en = 1'b0;
  logic [7:0] exp_q[$];
  int waits[$];          // cycles each payload byte waited for s_axis_tready

  uart_alu_engine #(.DATA_WIDTH(8), .OPERAND_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .cmd_error     (cmd_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Transmitter ready driver
  initial begin : ready_driver
    forever begin
      @(negedge clk);
      if (rdy_mode == 0) m_axis_tready = 1'b1;
      else if (rdy_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
      else m_axis_tready = man_rdy;
    end
  end

  // Monitor: pops the scoreboard on every response handshake
  initial begin : monitor
    logic       held;
    logic [7:0] held_data;
    logic [7:0] e;
    held = 1'b0;
    held_data = 8'h00;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        held = 1'b0;
      end else begin
        if (cmd_error) err_pulses++;
        if (held) begin
          check("hold_valid", 32'(m_axis_tvalid), 32'd1);
          check("hold_data", 32'(m_axis_tdata), 32'(held_data));
        end
        held = m_axis_tvalid && !m_axis_tready;
        held_data = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_byte: got=%02h expected=none", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            check("resp_byte", 32'(m_axis_tdata), 32'(e));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, output int waited);
    int n;
    @(negedge clk);
    if (gap_en && ($urandom_range(0, 3) == 0)) begin
      s_axis_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    n = 0;
    #2;
    while (!s_axis_tready && n < 1000) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!s_axis_tready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got=stalled expected=accept byte %02h", b);
    end
    @(posedge clk);
    waited = n;
  endtask

  task automatic idle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  // Reference model: operands are LE 32-bit words of the payload
  function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [7:0] pay[$]);
    logic [31:0] acc;
    logic [31:0] v;
    acc = 32'd0;
    for (int k = 0; k < pay.size() / 4; k++) begin
      v = {pay[4*k+3], pay[4*k+2], pay[4*k+1], pay[4*k]};
      if (k == 0) acc = v;
      else if (op == 8'hA0) acc = acc + v;
      else acc = acc * v;
    end
    return acc;
  endfunction

  task automatic run_packet(input logic [7:0] op, input int len, input logic [7:0] pay[$], input string tag);
    logic [15:0] len16;
    logic [7:0]  hdr[4];
    logic [31:0] res;
    bit          ok;
    int          w;
    int          e0;
    len16 = 16'(len);
    ok = (len >= 4) && ((op == 8'hEC) ||
         (((op == 8'hA0) || (op == 8'hA1)) && (len >= 12) && (len % 4 == 0)));
    res = 32'd0;
    if (ok && op == 8'hEC) begin
      foreach (pay[i]) exp_q.push_back(pay[i]);
    end else if (ok) begin
      res = alu_model(op, pay);
      for (int i = 0; i < 4; i++) exp_q.push_back(res[8*i +: 8]);
    end
    e0 = err_pulses;
    hdr[0] = op;
    hdr[1] = 8'($urandom);
    hdr[2] = len16[7:0];
    hdr[3] = len16[15:8];
    for (int i = 0; i < 4; i++) send_byte(hdr[i], w);
    waits = {};
    foreach (pay[i]) begin
      send_byte(pay[i], w);
      waits.push_back(w);
    end
    idle();
    repeat (2) @(negedge clk);
    check({"err_pulse_", tag}, 32'(err_pulses - e0), ok ? 32'd0 : 32'd1);
    $display("pkt %s op=%02h len=%0d accepted=%0d result=%08h", tag, op, len, ok, res);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
    exp_q = {};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, 32'(s_axis_tready), 32'd1);
    check({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_m_tdata"},  32'(m_axis_tdata),  32'd0);
    check({tag, "_busy"},     32'(busy),          32'd0);
    check({tag, "_cmd_error"},32'(cmd_error),     32'd0);
  endtask

  initial begin : stimulus
    logic [7:0] pay[$];
    logic [7:0] op;
    int len;
    int r;
    int w;
    int n;

    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ADD wrap
    pay = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_packet(8'hA0, 12, pay, "add_wrap");
    wait_drain("add_wrap");

    // MUL of 3, 5, 0x10000: 32 stall cycles per combine
    pay = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    run_packet(8'hA1, 16, pay, "mul3");
    check("mul_no_stall_first", 32'(waits[4]), 32'd0);
    check("mul_stall_cycles", 32'(waits[8]), 32'd32);
    wait_drain("mul3");

    // ADD of three operands: one stall cycle per combine
    pay = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h01};
    run_packet(8'hA0, 16, pay, "add3");
    check("add_stall_cycles", 32'(waits[8]), 32'd1);
    wait_drain("add3");

    // ECHO with random transmitter ready, then a normal packet
    rdy_mode = 1;
    pay = '{8'h41, 8'h42, 8'h43};
    run_packet(8'hEC, 7, pay, "echo");
    wait_drain("echo");
    rdy_mode = 0;

    // Rejected packets, then a valid follow-up
    pay = '{8'hAA, 8'hBB};
    run_packet(8'h55, 6, pay, "bad_op");
    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_packet(8'hA0, 10, pay, "bad_len");
    pay = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    run_packet(8'hA0, 12, pay, "add_2_3");
    wait_drain("after_err");

    // SEND backpressure mid-response
    rdy_mode = 2;
    man_rdy = 1'b0;
    pay = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h01, 8'h01, 8'h01, 8'h01};
    run_packet(8'hA0, 12, pay, "bp");
    @(posedge clk); #1 man_rdy = 1'b1;
    @(posedge clk); #1 man_rdy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #3;
      check("bp_s_tready", 32'(s_axis_tready), 32'd0);
      check("bp_m_tvalid", 32'(m_axis_tvalid), 32'd1);
    end
    check("bp_remaining", 32'(exp_q.size()), 32'd3);
    rdy_mode = 0;
    wait_drain("bp");

    // Reset during MUL
    pay = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00};
    send_byte(8'hA1, w); send_byte(8'h00, w); send_byte(8'h10, w); send_byte(8'h00, w);
    foreach (pay[i]) send_byte(pay[i], w);
    idle();
    repeat (5) @(negedge clk);
    #3;
    check("mul_s_tready_low", 32'(s_axis_tready), 32'd0);
    check("mul_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mul");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pay = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    run_packet(8'hA0, 12, pay, "after_rst_mul");
    wait_drain("after_rst_mul");

    // Reset during SEND after one byte delivered
    rdy_mode = 2;
    man_rdy = 1'b0;
    @(negedge clk);
    send_byte(8'hA0, w); send_byte(8'h00, w); send_byte(8'h0C, w); send_byte(8'h00, w);
    foreach (pay[i]) send_byte(pay[i], w);
    idle();
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!m_axis_tvalid && n < 50);
    check("send_valid_seen", 32'(m_axis_tvalid), 32'd1);
    exp_q.push_back(8'h05);
    @(posedge clk); #1 man_rdy = 1'b1;
    @(posedge clk); #1 man_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("partial_sent", 32'(exp_q.size()), 32'd0);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("rst_send");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rdy_mode = 0;
    run_packet(8'hA0, 12, pay, "after_rst_send");
    wait_drain("after_rst_send");

    // Randomized packets against the reference model
    gap_en = 1'b1;
    rdy_mode = 1;
    for (int p = 0; p < 30; p++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin op = 8'hA0; len = 4 + 4 * $urandom_range(2, 4); end
      else if (r <= 5) begin op = 8'hA1; len = 4 + 4 * $urandom_range(2, 3); end
      else if (r <= 7) begin op = 8'hEC; len = $urandom_range(0, 12); end
      else if (r == 8) begin
        op = 8'($urandom);
        while (op == 8'hEC || op == 8'hA0 || op == 8'hA1) op = op + 8'd1;
        len = $urandom_range(0, 10);
      end else begin
        op = ($urandom_range(0, 1) == 0) ? 8'hA0 : 8'hA1;
        len = $urandom_range(0, 16);
        if (len >= 12 && len % 4 == 0) len = len + 1;
      end
      pay = {};
      for (int i = 0; i < len - 4; i++) pay.push_back(8'($urandom));
      run_packet(op, len, pay, $sformatf("rand%0d", p));
    end
    wait_drain("rand");
    rdy_mode = 0;
    gap_en = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_s_tready", 32'(s_axis_tready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_alu_engine.md
# uart_alu_engine

Byte-stream command processor that sits between the UART receiver and the UART transmitter. It consumes command packets from the receiver's AXI-Stream byte output, executes echo, add or multiply over 32-bit operands, and emits response bytes into the transmitter's AXI-Stream input. Baud generation and framing stay in the UART cores; this block only parses, computes and serialises.

## Interface
- `DATA_WIDTH`, 8: stream byte width. Only 8 is supported.
- `OPERAND_WIDTH`, 32: operand and result width. Fixed at 4 bytes, little-endian.
- `clk` input 1: single clock for all logic.
- `rst` input 1: reset, asynchronous assert, active-low. All state clears while `rst`=0.
- `s_axis_tdata` input 8: command byte from the UART receiver.
- `s_axis_tvalid` input 1: command byte valid.
- `s_axis_tready` output 1: engine accepts a byte when this and `s_axis_tvalid` are both 1.
- `m_axis_tdata` output 8: response byte to the UART transmitter.
- `m_axis_tvalid` output 1: response byte valid.
- `m_axis_tready` input 1: transmitter accepts a byte when this and `m_axis_tvalid` are both 1.
- `busy` output 1: high in every state except HDR with header count 0.
- `cmd_error` output 1: one-cycle pulse when a packet is rejected.

## Operation
- Packet format: byte0 opcode, byte1 reserved (ignored), byte2-3 LEN (16-bit, LSB first, total packet bytes including the 4-byte header), then LEN-4 payload bytes.
- Opcodes:
  - 0xEC ECHO: payload is forwarded byte-for-byte.
  - 0xA0 ADD: sum of all 32-bit LE payload operands, mod 2^32.
  - 0xA1 MUL: product of all operands, low 32 bits kept.
- Validity rules for ADD/MUL: payload must be a multiple of 4 bytes and hold at least 2 operands (LEN ≥ 12, LEN[1:0]=0).
  - Any other opcode, LEN<4, or a malformed ADD/MUL length: pulse `cmd_error`, go to DRAIN for LEN-4 bytes, send no response.
  - When LEN<4, drain 0 bytes.
- States:
  - HDR: accept 4 bytes. On the 4th byte, go to one of ECHO, OPERAND, DRAIN, or back to HDR (ECHO with LEN=4).
  - ECHO: combinational pass-through. `m_axis_tdata`=`s_axis_tdata`, `m_axis_tvalid`=`s_axis_tvalid`, `s_axis_tready`=`m_axis_tready`. Count transfers and return to HDR after LEN-4.
  - OPERAND: assemble 4 bytes LSB first.
    - First operand loads the accumulator.
    - Subsequent operands go to ADD (1 cycle) or MUL.
    - After the last operand is combined, go to SEND; otherwise return to OPERAND.
  - MUL: iterative shift-add, 32 cycles, one multiplier bit per cycle. `s_axis_tready`=0.
  - SEND: present accumulator bytes 0..3 LSB first. Advance on each handshake and return to HDR after byte 3.
  - DRAIN: `s_axis_tready`=1, discard bytes, return to HDR when the count reaches 0.
- Payload counter is 16-bit, decremented per accepted payload byte. No wrap: LEN is at most 65535.

## Timing
- Reset values: `s_axis_tready`=1 (HDR), `m_axis_tvalid`=0, `m_axis_tdata`=0, `busy`=0, `cmd_error`=0, accumulator=0, counters=0.
- `s_axis_tready` states:
  - 1 in HDR, OPERAND and DRAIN.
  - Equal to `m_axis_tready` in ECHO.
  - 0 in ADD, MUL and SEND.
- ADD latency: handshake of the last byte of operand k at cycle t, ADD at t+1, and either OPERAND ready again at t+2 or SEND valid at t+2.
- MUL latency: handshake at cycle t, MUL for t+1..t+32, next state at t+33.
- SEND handshake: `m_axis_tvalid` and `m_axis_tdata` are registered and must hold stable until `m_axis_tready`=1.
- Back-to-back packets: the byte after a completed packet is a header byte with no dead cycle, except after SEND, where HDR is entered the cycle after the byte 3 handshake.
- `cmd_error` pulses in the cycle after the 4th header byte is accepted.
- An asynchronous reset mid-packet (any state) aborts immediately.
  - After release, the next accepted byte is an opcode.
  - A partially sent response is not completed.

## Test plan
- ADD: stream EC-less packet A0 00 0C 00 | 01 00 00 00 | FF FF FF FF -> response 00 00 00 00 (wrap), `cmd_error`=0.
- MUL, three operands: A0→A1 with LEN=0x10 and operands 3, 5, 0x10000 -> response 00 00 0F 00; MUL phase exactly 32 cycles per combine, with `s_axis_tready` low throughout.
- ECHO with `m_axis_tready` toggled randomly: EC 00 07 00 41 42 43 -> output 41 42 43. No byte lost or duplicated; next packet's header parsed correctly.
- Bad opcode and bad length:
  - 55 00 06 00 AA BB -> `cmd_error` one pulse, 2 bytes drained, no output.
  - A0 00 0A 00 + 6 bytes -> error, drain 6.
  - Follow-up valid ADD of 2+3 returns 05 00 00 00.
- SEND backpressure: hold `m_axis_tready`=0 for 10 cycles mid-response -> data stable, `s_axis_tready`=0, all 4 bytes delivered in order.
- Reset mid-MUL and mid-SEND: assert `rst`=0 asynchronously -> outputs at reset values within the same cycle; the following ADD packet completes correctly.
